// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the interrupt pending controller
package irq_pkg;

    localparam int NUM_IRQ     = 4;
    localparam int ID_W        = 2;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_CLEAR = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_sel.sv
// rtl/irq_prio_sel.sv - picks the highest-index eligible channel
module irq_prio_sel
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] eligible_i,
    output logic               any_o,
    output logic [ID_W-1:0]    sel_o
);

    // Ascending scan: the last hit is the highest index, which has priority.
    always_comb begin
        any_o = 1'b0;
        sel_o = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible_i[i]) begin
                any_o = 1'b1;
                sel_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// rtl/irq_pending_ctrl.sv - pending capture, masking and req/ack offer of four interrupt lines
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter bit EDGE    = 1'b1,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CW      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] mask,
    input  logic               ack,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic               timeout
);

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    irq_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic               irq_req_q, irq_req_d;
    logic               timeout_q, timeout_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] clr_vec;
    logic               sel_any;
    logic [ID_W-1:0]    sel_id;

    irq_prio_sel u_prio_sel (
        .eligible_i (pending_q & mask),
        .any_o      (sel_any),
        .sel_o      (sel_id)
    );

    assign set_vec = EDGE ? (irq_in & ~irq_prev_q) : irq_in;
    assign clr_vec = (state_q == ST_REQ && ack) ? (NUM_IRQ'(1) << irq_id_q) : '0;

    // A fresh set at the same edge as the clear keeps the bit pending.
    assign pending_d = set_vec | (pending_q & ~clr_vec);

    always_comb begin
        state_d   = state_q;
        irq_id_d  = irq_id_q;
        irq_req_d = irq_req_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_any) begin
                    state_d   = ST_REQ;
                    irq_id_d  = sel_id;
                    irq_req_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_d   = ST_CLEAR;
                    irq_req_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    irq_req_d = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                irq_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            irq_prev_q <= '0;
            irq_id_q   <= '0;
            irq_req_q  <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            irq_prev_q <= irq_in;
            irq_id_q   <= irq_id_d;
            irq_req_q  <= irq_req_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign irq_req = irq_req_q;
    assign irq_id  = irq_id_q;
    assign pending = pending_q;
    assign timeout = timeout_q;

endmodule
